// File: rtl/uart_tx_fifo_cfg_if.sv
// Write-side handshake bundle for uart_tx_fifo_cfg.
// master: the core-side producer drives wr_data/wr_valid and observes wr_ready.
// slave : the transmitter samples wr_data/wr_valid and drives wr_ready.
// A word is transferred on any clk edge where wr_valid && wr_ready.
interface uart_tx_fifo_cfg_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/uart_tx_fifo_cfg.sv
// FIFO-buffered UART transmitter with run-time parity and stop-bit selection.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   wr           - write handshake (wr_data, wr_valid, wr_ready = FIFO not full)
//   brd          - clk cycles per serial bit (0 behaves as 1), latched per frame
//   parity_mode  - 00/11 none, 01 even, 10 odd, latched per frame
//   two_stop     - 1 selects two stop bits, latched per frame
//   tx_en        - permits launching new frames
//   out_tx       - serial line, idle high
//   busy         - frame in progress
//   done         - pulse on the last cycle of the final stop bit
//   fifo_count   - occupied FIFO entries; fifo_empty when zero
//   overflow     - pulse when wr_valid is asserted while the FIFO is full
module uart_tx_fifo_cfg #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BRD_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    uart_tx_fifo_cfg_if.slave                wr,
    input  logic [BRD_W-1:0]                 brd,
    input  logic [1:0]                       parity_mode,
    input  logic                             two_stop,
    input  logic                             tx_en,
    output logic                             out_tx,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             fifo_empty,
    output logic                             overflow
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Per-frame shadow copies and bit timing
    logic [BRD_W-1:0]  baud_cnt_q;
    logic [BRD_W-1:0]  brd_q;
    logic [3:0]        bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic              has_par_q;
    logic              two_stop_q;

    logic              tick;
    logic              last_data;
    logic              last_stop;
    logic              launch;

    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign push       = wr.wr_valid && !full;
    assign pop        = launch;
    assign wr.wr_ready = !full;
    assign overflow   = wr.wr_valid && full;
    assign fifo_count = count_q;
    assign fifo_empty = empty;

    assign tick      = (baud_cnt_q == brd_q - BRD_W'(1));
    assign last_data = (bit_cnt_q == 4'(DATA_W - 1));
    assign last_stop = (bit_cnt_q == (two_stop_q ? 4'd1 : 4'd0));
    // done marks the final stop-bit cycle, which doubles as a launch slot.
    assign launch    = ((state_q == StIdle) || done) && tx_en && !empty;

    // FIFO pointers and occupancy; a push while full is simply not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= wr.wr_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (tick && last_data) begin
                    state_d = has_par_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (tick) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (done) begin
                    state_d = launch ? StStart : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        out_tx = 1'b1;
        busy   = (state_q != StIdle);
        done   = 1'b0;
        case (state_q)
            StStart:  out_tx = 1'b0;
            StData:   out_tx = shift_q[0];
            StParity: out_tx = parity_q;
            StStop: begin
                out_tx = 1'b1;
                done   = tick && last_stop;
            end
            default: out_tx = 1'b1;
        endcase
    end

    // Bit timing, shifter and launch-time shadow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            brd_q      <= '0;
            parity_q   <= 1'b0;
            has_par_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            if ((state_q == StIdle) || tick) begin
                baud_cnt_q <= '0;
            end else begin
                baud_cnt_q <= baud_cnt_q + BRD_W'(1);
            end

            // bit_cnt indexes bits within the current state only
            if (state_d != state_q) begin
                bit_cnt_q <= '0;
            end else if (tick && (state_q != StIdle)) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end

            if (launch) begin
                shift_q    <= head;
                brd_q      <= (brd == '0) ? BRD_W'(1) : brd;
                has_par_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                // even: p = XOR(data); odd: p = ~XOR(data)
                parity_q   <= (^head) ^ (parity_mode == 2'b10);
                two_stop_q <= two_stop;
            end else if ((state_q == StData) && tick) begin
                shift_q <= shift_q >> 1;
            end
        end
    end
endmodule
